store_sequencer: RTL and testbench
==================================

// Module: store_sequencer
// PURPOSE
//  Sequences CPU store requests (SB/SH/SW) into data memory over a req/ack bus.
//  Sits between the MEM-stage store issue and the data memory write port.
//  Generates byte lanes and lane-aligned write data itself.
//  Splits word-crossing stores into two aligned beats.
//  Flags illegal types and memory timeouts.
// PARAMETERS
//  SPLIT_EN  1   1: split misaligned SH/SW into two beats; 0: misaligned -> err, no write
//  TIMEOUT   16  max cycles mem_req may wait for mem_ack before abort; 0 = wait forever
//  TO_W      5   width of timeout counter; TIMEOUT < 2**TO_W
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous reset, active-high
//  req_valid  in   1   store request valid
//  req_ready  out  1   sequencer can accept (high only in IDLE)
//  req_type   in   2   00=SB 01=SH 10=SW 11=illegal
//  req_addr   in   32  byte address
//  req_data   in   32  rs2 data; SB uses [7:0], SH uses [15:0]
//  mem_req    out  1   memory write request, held until mem_ack
//  mem_addr   out  32  word-aligned address ([1:0]=00)
//  mem_wdata  out  32  lane-positioned write data
//  mem_be     out  4   byte enables, bit i = byte lane i
//  mem_ack    in   1   memory accepted current beat (sampled only while mem_req=1)
//  done       out  1   1-cycle pulse: store fully written
//  err        out  1   1-cycle pulse: illegal type, disallowed misalign, or timeout
// BEHAVIOUR
//  Interface and reset
//  - Reset values: state=IDLE; req_ready=1; mem_req=0; mem_addr=0; mem_wdata=0; mem_be=0; done=0; err=0.
//  - All outputs are registered; req_ready=(state==IDLE).
//  Request acceptance
//  - Accept on req_valid&&req_ready; latch type/addr/data.
//  - Let off=addr[1:0] and size=1/2/4 bytes for SB/SH/SW.
//  - Split when off+size>4: SH off=3; SW off!=0.
//  - Illegal type, or split with SPLIT_EN=0: next cycle err=1, stay IDLE, no mem_req, no done.
//  FSM: IDLE -> LO -> (HI) -> IDLE
//  - LO beat: mem_addr={addr[31:2],2'b00}.
//  - LO beat: mem_be=(size mask << off)[3:0].
//  - LO beat: mem_wdata=data<<(8*off).
//  - HI beat: mem_addr=LO addr+4, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
//  - HI beat: mem_be=(size mask << off)[7:4].
//  - HI beat: mem_wdata=data>>(8*(4-off)).
//  - Unused wdata lanes are 0.
//  - mem_req rises the cycle after acceptance. mem_addr, mem_wdata and mem_be stay stable while mem_req=1.
//  - On mem_ack in LO with split: mem_req stays 1; the next cycle presents the HI beat.
//  - On final mem_ack: next cycle mem_req=0, done=1, state=IDLE, req_ready=1.
//  - Minimum latency: accept at T, mem_req at T+1, ack at T+1, done at T+2, next accept at T+2.
//  Timeout
//  - Counter clears on each new beat and increments each cycle mem_req=1 && !mem_ack.
//  - When counter==TIMEOUT (TIMEOUT!=0): abort, next cycle mem_req=0, err=1, IDLE, no done.
//  - A LO beat already acked is not rolled back.
//  - mem_ack in the same cycle as the timeout hit wins: no timeout.
//  Boundary rules
//  - done and err are never high together.
//  - mem_ack while mem_req=0 is ignored.
//  - rst mid-operation: everything returns to reset values the next edge; a pending HI beat is dropped.
// TESTING
//  - SW addr=0x100 data=0xDEADBEEF, ack immediately -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF; done at T+2.
//  - SB addr=0x203 data=0x000000A5 -> addr 0x200, be 1000, wdata 0xA5000000; SH addr=0x202 data=0x1234 -> be 1100, wdata 0x12340000.
//  - SW addr=0x101 data=0x11223344, SPLIT_EN=1 -> LO: 0x100, be 1110, wdata 0x22334400; HI: 0x104, be 0001, wdata 0x00000011; one done.
//  - SH addr=0xFFFFFFFF data=0xABCD -> LO: 0xFFFFFFFC, be 1000, wdata 0xCD000000; HI: 0x00000000, be 0001, wdata 0x000000AB.
//  - req_type=11, or SW addr=0x102 with SPLIT_EN=0 -> err pulse; mem_req never asserts; req_ready stays 1.
//  - TIMEOUT=4, mem_ack held low -> mem_req high for 4 cycles, then err pulse, IDLE.
//  - Reset variant: rst asserted between the LO ack and the HI beat -> HI beat never issued, all outputs at reset values.

Source files
------------

// File: rtl/store_sequencer.sv
// store_sequencer: turns SB/SH/SW store requests into lane-aligned
// memory write beats over a req/ack bus. A store that crosses a word
// boundary is issued as a LO beat followed by a HI beat at the next word.
// Illegal types, disallowed misalignment and ack timeouts produce a
// one-cycle err pulse. A fully written store produces a one-cycle done pulse.
module store_sequencer #(
  parameter int SPLIT_EN = 1,
  parameter int TIMEOUT  = 16,
  parameter int TO_W     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10
  } state_t;

  localparam logic            TO_EN  = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  // Byte-lane mask of an unshifted store of the given type.
  function automatic logic [3:0] size_mask(input logic [1:0] t);
    logic [3:0] m;
    case (t)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Zero every byte of the store data that lies outside the store size.
  function automatic logic [31:0] size_data(input logic [3:0] m, input logic [31:0] d);
    return d & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  state_t          state_r, state_nxt_s;
  logic            req_ready_r, req_ready_nxt_s;
  logic            mem_req_r, mem_req_nxt_s;
  logic [31:0]     mem_addr_r, mem_addr_nxt_s;
  logic [31:0]     mem_wdata_r, mem_wdata_nxt_s;
  logic [3:0]      mem_be_r, mem_be_nxt_s;
  logic            done_r, done_nxt_s;
  logic            err_r, err_nxt_s;
  logic            split_r, split_nxt_s;
  logic [31:0]     hi_addr_r, hi_addr_nxt_s;
  logic [31:0]     hi_wdata_r, hi_wdata_nxt_s;
  logic [3:0]      hi_be_r, hi_be_nxt_s;
  logic [TO_W-1:0] cnt_r, cnt_nxt_s;

  logic [3:0]      mask_s;
  logic [7:0]      be_wide_s;
  logic [63:0]     wdata_wide_s;
  logic            split_s;
  logic            illegal_s;
  logic [31:0]     lo_addr_s;
  logic [TO_W-1:0] cnt_inc_s;

  assign req_ready = req_ready_r;
  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_be    = mem_be_r;
  assign done      = done_r;
  assign err       = err_r;

  // Decode the incoming request into both beats over an 8-byte window.
  always_comb begin
    mask_s       = size_mask(req_type);
    be_wide_s    = {4'b0000, mask_s} << req_addr[1:0];
    wdata_wide_s = {32'h0000_0000, size_data(mask_s, req_data)} << {req_addr[1:0], 3'b000};
    split_s      = (be_wide_s[7:4] != 4'b0000);
    illegal_s    = (req_type == 2'b11) || (split_s && (SPLIT_EN == 0));
    lo_addr_s    = {req_addr[31:2], 2'b00};
    cnt_inc_s    = cnt_r + TO_W'(1);
  end

  // Next-state and next-output logic for the IDLE/LO/HI sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    mem_req_nxt_s   = mem_req_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    mem_be_nxt_s    = mem_be_r;
    done_nxt_s      = 1'b0;
    err_nxt_s       = 1'b0;
    split_nxt_s     = split_r;
    hi_addr_nxt_s   = hi_addr_r;
    hi_wdata_nxt_s  = hi_wdata_r;
    hi_be_nxt_s     = hi_be_r;
    cnt_nxt_s       = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          if (illegal_s) begin
            err_nxt_s = 1'b1;
          end else begin
            state_nxt_s     = ST_LO;
            mem_req_nxt_s   = 1'b1;
            mem_addr_nxt_s  = lo_addr_s;
            mem_be_nxt_s    = be_wide_s[3:0];
            mem_wdata_nxt_s = wdata_wide_s[31:0];
            hi_addr_nxt_s   = lo_addr_s + 32'd4;
            hi_be_nxt_s     = be_wide_s[7:4];
            hi_wdata_nxt_s  = wdata_wide_s[63:32];
            split_nxt_s     = split_s;
            cnt_nxt_s       = '0;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_LO, ST_HI: begin
        if (mem_ack) begin
          if ((state_r == ST_LO) && split_r) begin
            state_nxt_s     = ST_HI;
            mem_addr_nxt_s  = hi_addr_r;
            mem_be_nxt_s    = hi_be_r;
            mem_wdata_nxt_s = hi_wdata_r;
            cnt_nxt_s       = '0;
          end else begin
            state_nxt_s   = ST_IDLE;
            mem_req_nxt_s = 1'b0;
            done_nxt_s    = 1'b1;
          end
        end else if (TO_EN && (cnt_inc_s == TO_LIM)) begin
          // The wait that would reach the limit is the last one allowed.
          state_nxt_s   = ST_IDLE;
          mem_req_nxt_s = 1'b0;
          err_nxt_s     = 1'b1;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        mem_req_nxt_s = 1'b0;
      end
    endcase
    req_ready_nxt_s = (state_nxt_s == ST_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      split_r     <= 1'b0;
      hi_addr_r   <= 32'h0000_0000;
      hi_wdata_r  <= 32'h0000_0000;
      hi_be_r     <= 4'b0000;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_nxt_s;
      req_ready_r <= req_ready_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      mem_be_r    <= mem_be_nxt_s;
      done_r      <= done_nxt_s;
      err_r       <= err_nxt_s;
      split_r     <= split_nxt_s;
      hi_addr_r   <= hi_addr_nxt_s;
      hi_wdata_r  <= hi_wdata_nxt_s;
      hi_be_r     <= hi_be_nxt_s;
      cnt_r       <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: a vector table of stores with expected beats
// pushed into a scoreboard queue, popped by a bus monitor on every acked
// beat, plus hand-written timeout, split-disabled and reset sequences.
module tb_store_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid2;
  logic [1:0]  req_type;
  logic [31:0] req_addr, req_data;
  logic        ack_auto, ack_force;

  logic        req_ready, mem_req, mem_ack, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        req_ready2, mem_req2, mem_ack2, done2, err2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [3:0]  mem_be2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] w;
  } beat_t;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    int          nb;
    beat_t       b0;
    beat_t       b1;
    logic        e;
    int          lat;
  } vec_t;

  beat_t exp_q[$];
  beat_t eb;
  vec_t  vt[11];

  always #5 clk = ~clk;

  assign mem_ack  = ack_force | (ack_auto & mem_req);
  assign mem_ack2 = ack_auto & mem_req2;

  store_sequencer #(.SPLIT_EN(1), .TIMEOUT(4), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .done(done), .err(err)
  );

  store_sequencer #(.SPLIT_EN(0), .TIMEOUT(0), .TO_W(5)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_be(mem_be2), .mem_ack(mem_ack2), .done(done2), .err(err2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic beat_t bt(input logic [31:0] a, input logic [3:0] b, input logic [31:0] w);
    beat_t r;
    r.a = a; r.b = b; r.w = w;
    return r;
  endfunction

  function automatic vec_t mk(input logic [1:0] typ, input logic [31:0] addr, input logic [31:0] data,
                              input int nb, input beat_t b0, input beat_t b1, input logic e, input int lat);
    vec_t v;
    v.typ = typ; v.addr = addr; v.data = data; v.nb = nb;
    v.b0 = b0; v.b1 = b1; v.e = e; v.lat = lat;
    return v;
  endfunction

  // Bus monitor: every acked beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ack) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", {32'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          eb = exp_q.pop_front();
          chk("beat_addr", {32'h0, mem_addr}, {32'h0, eb.a});
          chk("beat_be", {60'h0, mem_be}, {60'h0, eb.b});
          chk("beat_wdata", {32'h0, mem_wdata}, {32'h0, eb.w});
        end
      end
      if (mem_req) chk("ready_low_while_busy", {63'h0, req_ready}, 64'h0);
      if (done && err) chk("done_and_err", 64'h1, 64'h0);
    end
  end

  // Drive one table vector from a negedge and wait for done/err.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    lat = 0;
    chk($sformatf("v%0d_ready", idx), {63'h0, req_ready}, 64'h1);
    if (!v.e) begin
      exp_q.push_back(v.b0);
      if (v.nb == 2) exp_q.push_back(v.b1);
    end
    req_type = v.typ; req_addr = v.addr; req_data = v.data; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done || err) begin
        lat = c;
        break;
      end
    end
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_done", idx), {63'h0, done}, {63'h0, !v.e});
    chk($sformatf("v%0d_err", idx), {63'h0, err}, {63'h0, v.e});
    chk($sformatf("v%0d_beats_left", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int nreq, lat_e, nerr, nbusy;
    rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
    req_type = 2'b00; req_addr = 32'h0; req_data = 32'h0;
    ack_auto = 1'b1; ack_force = 1'b0;

    vt[0]  = mk(2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 1, bt(32'h100, 4'b1111, 32'hDEAD_BEEF), bt(32'h0, 4'h0, 32'h0), 1'b0, 2);
    vt[1]  = mk(2'b00, 32'h0000_0203, 32'h0000_00A5, 1, bt(32'h200, 4'b1000, 32'hA500_0000), bt(32'h0, 4'h0, 32'h0), 1'b0, 2);
    vt[2]  = mk(2'b01, 32'h0000_0202, 32'h0000_1234, 1, bt(32'h200, 4'b1100, 32'h1234_0000), bt(32'h0, 4'h0, 32'h0), 1'b0, 2);
    vt[3]  = mk(2'b10, 32'h0000_0101, 32'h1122_3344, 2, bt(32'h100, 4'b1110, 32'h2233_4400), bt(32'h104, 4'b0001, 32'h0000_0011), 1'b0, 3);
    vt[4]  = mk(2'b01, 32'hFFFF_FFFF, 32'h0000_ABCD, 2, bt(32'hFFFF_FFFC, 4'b1000, 32'hCD00_0000), bt(32'h0, 4'b0001, 32'h0000_00AB), 1'b0, 3);
    vt[5]  = mk(2'b11, 32'h0000_0040, 32'h1234_5678, 0, bt(32'h0, 4'h0, 32'h0), bt(32'h0, 4'h0, 32'h0), 1'b1, 1);
    vt[6]  = mk(2'b00, 32'h0000_0201, 32'h1234_56C3, 1, bt(32'h200, 4'b0010, 32'h0000_C300), bt(32'h0, 4'h0, 32'h0), 1'b0, 2);
    vt[7]  = mk(2'b01, 32'h0000_0201, 32'hFFFF_5A5A, 1, bt(32'h200, 4'b0110, 32'h005A_5A00), bt(32'h0, 4'h0, 32'h0), 1'b0, 2);
    vt[8]  = mk(2'b10, 32'h0000_0103, 32'hA1B2_C3D4, 2, bt(32'h100, 4'b1000, 32'hD400_0000), bt(32'h104, 4'b0111, 32'h00A1_B2C3), 1'b0, 3);
    vt[9]  = mk(2'b10, 32'h0000_0102, 32'h5566_7788, 2, bt(32'h100, 4'b1100, 32'h7788_0000), bt(32'h104, 4'b0011, 32'h0000_5566), 1'b0, 3);
    vt[10] = mk(2'b01, 32'h0000_0203, 32'h9999_BEEF, 2, bt(32'h200, 4'b1000, 32'hEF00_0000), bt(32'h204, 4'b0001, 32'h0000_00BE), 1'b0, 3);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
    chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
    chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
    chk("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
    chk("rst_mem_be", {60'h0, mem_be}, 64'h0);
    chk("rst_done_err", {62'h0, done, err}, 64'h0);
    rst = 1'b0;

    // Table of stores, acked immediately
    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // Ack on a idle bus is ignored
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ack_mem_req", {63'h0, mem_req}, 64'h0);
    chk("idle_ack_done", {63'h0, done}, 64'h0);
    ack_force = 1'b0;

    // Timeout: ack never comes
    ack_auto = 1'b0; nreq = 0; lat_e = 0;
    req_type = 2'b10; req_addr = 32'h100; req_data = 32'h0BAD_F00D; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem_req) nreq++;
      if (err || done) begin
        lat_e = c;
        break;
      end
    end
    chk("to_req_cycles", nreq, 4);
    chk("to_err_cycle", lat_e, 5);
    chk("to_err", {63'h0, err}, 64'h1);
    chk("to_no_done", {63'h0, done}, 64'h0);
    chk("to_idle_ready", {62'h0, req_ready, mem_req}, 64'h2);

    // Ack in the very cycle the timeout would fire wins
    exp_q.push_back(bt(32'h100, 4'b1111, 32'hCAFE_F00D));
    req_type = 2'b10; req_addr = 32'h100; req_data = 32'hCAFE_F00D; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_ack_stable_addr", {32'h0, mem_addr}, 64'h100);
    chk("late_ack_still_req", {63'h0, mem_req}, 64'h1);
    ack_force = 1'b1;
    @(posedge clk);
    #1 ack_force = 1'b0;
    chk("late_ack_done_err", {62'h0, done, err}, 64'h2);
    chk("late_ack_beats_left", exp_q.size(), 0);
    @(negedge clk);

    // Reset between the LO ack and the HI beat
    exp_q.push_back(bt(32'h100, 4'b1110, 32'h2233_4400));
    req_type = 2'b10; req_addr = 32'h101; req_data = 32'h1122_3344; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; ack_force = 1'b1;
    @(posedge clk);
    #1 ack_force = 1'b0; rst = 1'b1;
    chk("rv_hi_presented", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h104});
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rv_outputs", {mem_req, done, err, req_ready, mem_be, mem_addr, 24'h0},
        {1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0, 24'h0});
    chk("rv_wdata", {32'h0, mem_wdata}, 64'h0);
    ack_auto = 1'b1;
    nbusy = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_req || done) nbusy++;
    end
    chk("rv_hi_dropped", nbusy, 0);
    chk("rv_beats_left", exp_q.size(), 0);

    // Split disabled: misaligned SW reports err only
    nreq = 0; nerr = 0; nbusy = 0; lat_e = 0;
    req_type = 2'b10; req_addr = 32'h102; req_data = 32'h5566_7788; req_valid2 = 1'b1;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (mem_req2) nreq++;
      if (!req_ready2) nbusy++;
      if (err2) begin
        nerr++;
        lat_e = c;
      end
      if (done2) nbusy++;
    end
    chk("ns_err_pulses", nerr, 1);
    chk("ns_err_cycle", lat_e, 1);
    chk("ns_no_mem_req", nreq, 0);
    chk("ns_ready_done", nbusy, 0);
    chk("ns_outputs_idle", {mem_be2, mem_addr2, mem_wdata2}, 68'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
